stack_port_ctl: RTL and testbench
=================================

Name: stack_port_ctl

Overview:
- Initiator-side controller for the data/return stack primitive: turns a valid/ready command stream (push, pop, replace, dump) into the stack's `we`/`delta`/`wd` controls.
- Pops and dumps return their data to the requester on a valid/ready output stream.
- Tracks occupancy and raises sticky overflow/underflow flags, so illegal operations never reach the stack.
- Sits between a host or debug port and one stack instance, e.g. for bench-driven loading and readout of the J1 stacks.

Parameters:
- DEPTH, 18: tail depth of the attached stack; total capacity CAP = DEPTH+1 (head plus tail).
- CW, 5: width of depth and count fields; must satisfy 2^CW > CAP.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_op  in  2  00 replace top, 01 push, 10 pop, 11 dump
- cmd_data  in  16  write data for push/replace
- cmd_count  in  CW  dump length; 0 = dump entire stack
- out_valid  out  1  popped word available
- out_ready  in  1  consumer accepts out_data
- out_data  out  16  popped word (current top of stack)
- stk_we  out  1  to stack `we`
- stk_delta  out  2  to stack `delta`: 00 hold, 01 push, 11 pop
- stk_wd  out  16  to stack `wd`
- stk_rd  in  16  from stack `rd` (top of stack)
- depth  out  CW  current occupancy, 0..CAP
- ovf  out  1  sticky overflow flag
- unf  out  1  sticky underflow flag
- err_clr  in  1  synchronous clear of ovf/unf

Behaviour:
- Reset (async, active-high):
  - state=IDLE, depth=0, ovf=0, unf=0, out_valid=0, remaining count=0.
  - stk_we=0, stk_delta=00.
  - Stack contents are not reset; the controller treats the stack as empty.
- States: IDLE, EMIT.
- cmd_ready = (state==IDLE). Commands are accepted only on cycles with cmd_valid & cmd_ready.
- The stk_* outputs are combinational from state and accept, so the stack updates on the same edge that accepts the command. stk_rd reflects the new top from the next cycle.
- stk_wd = cmd_data at all times.
- Push accepted:
  - If depth<CAP: stk_we=1, stk_delta=01, depth+1.
  - If depth==CAP: no stack activity, ovf<=1, depth unchanged.
  - Either way 1-cycle occupancy; stays in IDLE.
- Replace accepted:
  - If depth>=1: stk_we=1, stk_delta=00, depth unchanged.
  - If depth==0: ignored, unf<=1.
- Pop accepted:
  - If depth==0: ignored, unf<=1, no output.
  - Otherwise remaining<=1 and go to EMIT.
- Dump accepted:
  - If depth==0: ignored, unf<=1.
  - Otherwise remaining <= (cmd_count==0 or cmd_count>depth) ? depth : cmd_count, and go to EMIT.
  - A cmd_count exceeding depth is clipped silently; no unf is raised.
- EMIT:
  - out_valid=1, out_data=stk_rd.
  - out_valid asserts the cycle after acceptance, at the earliest.
  - out_data must hold stable while out_valid & !out_ready.
  - On out_valid & out_ready: stk_delta=11, stk_we=0, depth-1, remaining-1. If remaining becomes 0, go to IDLE; otherwise stay in EMIT, and the next word (new stk_rd) is presented on the following cycle.
  - Back-to-back handshakes give one word per cycle.
- Flags:
  - ovf/unf are sticky until err_clr.
  - If err_clr coincides with a new error, the new error wins (flag stays 1).
- The controller never issues push at depth CAP or pop at depth 0; stk_delta is never 10.
- Reset asserted mid-EMIT aborts immediately: out_valid drops asynchronously, depth=0, and no further stack activity occurs.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 back-to-back → each accepted in 1 cycle; depth=3; stk_rd=0x3333; stk_delta pulses 01 three times.
- Replace 0xBEEF at depth 3, then pop with out_ready=1 → out_data=0xBEEF; depth=2; stk_rd then 0x2222; no flags.
- Dump count=0 at depth 2 with out_ready toggling 1,0,1 → words 0x2222 then 0x1111; out_data held during the stall; depth=0; returns to IDLE with cmd_ready=1.
- Pop and replace at depth 0 → no out_valid, stk_delta stays 00, unf=1; err_clr → unf=0.
- Push CAP=19 distinct words, then a 20th push → ovf=1; depth=19; the 20th word is not written; dump count=19 returns the words in LIFO order.
- Assert reset mid-dump after 2 of 5 words → out_valid=0, depth=0, cmd_ready=1 after reset release; a following pop sets unf=1.

Source files
------------

// File: rtl/stack_port_ctl.sv
// stack_port_ctl: initiator-side controller for one data/return stack.
// Converts a valid/ready command stream (replace/push/pop/dump) into the
// stack's we/delta/wd controls, returns popped words on a valid/ready output
// stream, tracks occupancy and keeps sticky overflow/underflow flags.
module stack_port_ctl #(
   parameter int DEPTH = 18,
   parameter int CW    = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [15:0]   cmd_data,
   input  logic [CW-1:0] cmd_count,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [15:0]   out_data,
   output logic          stk_we,
   output logic [1:0]    stk_delta,
   output logic [15:0]   stk_wd,
   input  logic [15:0]   stk_rd,
   output logic [CW-1:0] depth,
   output logic          ovf,
   output logic          unf,
   input  logic          err_clr
);

   // Head register plus tail entries.
   localparam logic [CW-1:0] CAP = CW'(DEPTH + 1);

   localparam logic [1:0] D_HOLD = 2'b00;
   localparam logic [1:0] D_PUSH = 2'b01;
   localparam logic [1:0] D_POP  = 2'b11;

   typedef enum logic {IDLE, EMIT} state_t;
   typedef enum logic [1:0] {
      OP_REPLACE = 2'b00,
      OP_PUSH    = 2'b01,
      OP_POP     = 2'b10,
      OP_DUMP    = 2'b11
   } op_t;

   state_t        state, state_nxt;
   logic [CW-1:0] depth_nxt;
   logic [CW-1:0] rem, rem_nxt;
   logic          ovf_set, unf_set;

   assign cmd_ready = (state == IDLE);
   assign out_valid = (state == EMIT);
   assign out_data  = stk_rd;
   assign stk_wd    = cmd_data;

   // Next state, occupancy bookkeeping and same-cycle stack controls.
   always_comb begin
      state_nxt = state;
      depth_nxt = depth;
      rem_nxt   = rem;
      stk_we    = 1'b0;
      stk_delta = D_HOLD;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               case (op_t'(cmd_op))
                  OP_PUSH: begin
                     if (depth < CAP) begin
                        stk_we    = 1'b1;
                        stk_delta = D_PUSH;
                        depth_nxt = depth + 1'b1;
                     end else begin
                        ovf_set = 1'b1;
                     end
                  end
                  OP_REPLACE: begin
                     if (depth != '0) stk_we = 1'b1;
                     else             unf_set = 1'b1;
                  end
                  OP_POP: begin
                     if (depth == '0) begin
                        unf_set = 1'b1;
                     end else begin
                        rem_nxt   = CW'(1);
                        state_nxt = EMIT;
                     end
                  end
                  OP_DUMP: begin
                     if (depth == '0) begin
                        unf_set = 1'b1;
                     end else begin
                        // Oversized counts clip to the current occupancy.
                        rem_nxt   = (cmd_count == '0 || cmd_count > depth) ? depth : cmd_count;
                        state_nxt = EMIT;
                     end
                  end
                  default: ;
               endcase
            end
         end
         EMIT: begin
            // The word on stk_rd is consumed; drop it from the stack on the same edge.
            if (out_ready) begin
               stk_delta = D_POP;
               depth_nxt = depth - 1'b1;
               rem_nxt   = rem - 1'b1;
               if (rem == CW'(1)) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, occupancy and sticky error flags; a new error beats err_clr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         depth <= '0;
         rem   <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         state <= state_nxt;
         depth <= depth_nxt;
         rem   <= rem_nxt;
         ovf   <= ovf_set | (ovf & ~err_clr);
         unf   <= unf_set | (unf & ~err_clr);
      end
   end

endmodule

// File: tb/tb_stack_port_ctl.sv
// tb_stack_port_ctl: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the controller's logical stack contents.
module tb_stack_port_ctl;

   localparam int CW  = 5;
   localparam int CAP = 19;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [15:0]   cmd_data = '0;
   logic [CW-1:0] cmd_count = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [15:0]   out_data;
   logic          stk_we;
   logic [1:0]    stk_delta;
   logic [15:0]   stk_wd;
   logic [15:0]   stk_rd = '0;
   logic [CW-1:0] depth;
   logic          ovf, unf;
   logic          err_clr = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   stack_port_ctl #(.DEPTH(18), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_count(cmd_count),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stk_we(stk_we), .stk_delta(stk_delta), .stk_wd(stk_wd), .stk_rd(stk_rd),
      .depth(depth), .ovf(ovf), .unf(unf), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Physical stack attached to the DUT: controls sampled mid-cycle, applied on the edge.
   logic [15:0] mem[$];
   logic        cap_we;
   logic [1:0]  cap_delta;
   logic [15:0] cap_wd;
   always @(negedge clk) begin
      cap_we    = stk_we;
      cap_delta = stk_delta;
      cap_wd    = stk_wd;
   end
   always @(posedge clk) begin
      if (!reset) begin
         case (cap_delta)
            2'b01: mem.push_back(cap_wd);
            2'b11: if (mem.size() > 0) void'(mem.pop_back());
            2'b00: if (cap_we && mem.size() > 0) mem[mem.size()-1] = cap_wd;
            default: ;
         endcase
         stk_rd = (mem.size() > 0) ? mem[mem.size()-1] : 16'h0000;
      end
   end

   // Behavioural model: logical contents, words still owed to the consumer, flags.
   logic [15:0] m_q[$];
   int          m_rem = 0;
   bit          m_ovf = 0, m_unf = 0;

   // Compare process: check every cycle, then advance the model with this cycle's inputs.
   always @(negedge clk) begin
      bit       e_we, n_ovf, n_unf;
      logic [1:0] e_d;
      int       sz, cnt;
      if (reset) begin
         m_q.delete();
         m_rem = 0; m_ovf = 0; m_unf = 0;
         chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
         chk("rst_valid", {31'b0, out_valid}, 32'd0);
         chk("rst_depth", 32'(depth), 32'd0);
         chk("rst_flags", {30'b0, ovf, unf}, 32'd0);
         chk("rst_delta", {29'b0, stk_we, stk_delta}, 32'd0);
      end else begin
         sz = m_q.size();
         chk("ready", {31'b0, cmd_ready}, {31'b0, (m_rem == 0)});
         chk("valid", {31'b0, out_valid}, {31'b0, (m_rem > 0)});
         chk("depth", 32'(depth), 32'(sz));
         chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
         chk("unf", {31'b0, unf}, {31'b0, m_unf});
         if (m_rem > 0) chk("out_data", 32'(out_data), 32'(m_q[sz-1]));
         e_we = 0; e_d = 2'b00;
         if (m_rem == 0 && cmd_valid) begin
            if (cmd_op == 2'b01 && sz < CAP) begin e_we = 1; e_d = 2'b01; end
            else if (cmd_op == 2'b00 && sz > 0) e_we = 1;
         end else if (m_rem > 0 && out_ready) begin
            e_d = 2'b11;
         end
         chk("stk_ctl", {29'b0, stk_we, stk_delta}, {29'b0, e_we, e_d});
         if (e_we) chk("stk_wd", 32'(stk_wd), 32'(cmd_data));

         n_ovf = 0; n_unf = 0;
         if (m_rem == 0 && cmd_valid) begin
            case (cmd_op)
               2'b01: if (sz < CAP) m_q.push_back(cmd_data); else n_ovf = 1;
               2'b00: if (sz > 0) m_q[sz-1] = cmd_data; else n_unf = 1;
               2'b10: if (sz > 0) m_rem = 1; else n_unf = 1;
               default: begin
                  cnt = int'(cmd_count);
                  if (sz == 0) n_unf = 1;
                  else m_rem = (cnt == 0 || cnt > sz) ? sz : cnt;
               end
            endcase
         end else if (m_rem > 0 && out_ready) begin
            void'(m_q.pop_back());
            m_rem--;
         end
         m_ovf = n_ovf | (m_ovf & !err_clr);
         m_unf = n_unf | (m_unf & !err_clr);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Offer one command until accepted (bounded); returns cycles taken.
   task automatic send(input logic [1:0] op, input logic [15:0] d,
                       input logic [CW-1:0] c, output int unsigned n);
      logic acc;
      n = 0;
      cmd_op = op; cmd_data = d; cmd_count = c; cmd_valid = 1'b1;
      do begin
         acc = cmd_ready;
         cyc();
         n++;
      end while (!acc && n < 60);
      cmd_valid = 1'b0;
      chk("cmd_accept", {31'b0, acc}, 32'd1);
   endtask

   initial begin
      int unsigned n;
      logic [15:0] held;
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      logic [15:0] held;
      int unsigned r;

      repeat (3) cyc();
      reset = 1'b0;
      chk("reset_depth", 32'(depth), 32'd0);
      chk("reset_ready", {31'b0, cmd_ready}, 32'd1);

      // Three back-to-back pushes.
      send(2'b01, 16'h1111, '0, n); chk("push1_lat", n, 32'd1);
      send(2'b01, 16'h2222, '0, n); chk("push2_lat", n, 32'd1);
      send(2'b01, 16'h3333, '0, n); chk("push3_lat", n, 32'd1);
      chk("depth3", 32'(depth), 32'd3);
      chk("top3333", 32'(stk_rd), 32'h3333);

      // Replace then pop.
      send(2'b00, 16'hBEEF, '0, n);
      out_ready = 1'b1;
      send(2'b10, 16'h0, '0, n);
      chk("pop_valid", {31'b0, out_valid}, 32'd1);
      chk("pop_data", 32'(out_data), 32'hBEEF);
      cyc();
      chk("pop_done", {31'b0, out_valid}, 32'd0);
      chk("pop_depth", 32'(depth), 32'd2);
      chk("pop_top", 32'(stk_rd), 32'h2222);
      chk("pop_flags", {30'b0, ovf, unf}, 32'd0);

      // Dump all with a stall on the second word.
      send(2'b11, 16'h0, '0, n);
      chk("dump_w0", 32'(out_data), 32'h2222);
      cyc();
      out_ready = 1'b0;
      chk("dump_w1", 32'(out_data), 32'h1111);
      cyc();
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_hold", 32'(out_data), 32'h1111);
      out_ready = 1'b1;
      cyc();
      chk("dump_end_valid", {31'b0, out_valid}, 32'd0);
      chk("dump_end_depth", 32'(depth), 32'd0);
      chk("dump_end_ready", {31'b0, cmd_ready}, 32'd1);

      // Underflow on empty, then clear.
      send(2'b10, 16'h0, '0, n);
      chk("unf_pop_valid", {31'b0, out_valid}, 32'd0);
      chk("unf_pop", {31'b0, unf}, 32'd1);
      send(2'b00, 16'h5555, '0, n);
      chk("unf_rep_depth", 32'(depth), 32'd0);
      err_clr = 1'b1; cyc(); err_clr = 1'b0;
      chk("unf_clr", {31'b0, unf}, 32'd0);

      // Fill to capacity, overflow, LIFO readout.
      for (int i = 0; i < CAP; i++) send(2'b01, 16'hA000 + 16'(i), '0, n);
      send(2'b01, 16'hDEAD, '0, n);
      chk("ovf_set", {31'b0, ovf}, 32'd1);
      chk("full_depth", 32'(depth), 32'd19);
      chk("full_top", 32'(stk_rd), 32'hA012);
      send(2'b11, 16'h0, CW'(19), n);
      for (int k = 0; k < CAP; k++) begin
         chk("lifo_data", 32'(out_data), 32'hA000 + 32'(CAP - 1 - k));
         cyc();
      end
      chk("lifo_idle", {31'b0, cmd_ready}, 32'd1);
      chk("lifo_depth", 32'(depth), 32'd0);
      err_clr = 1'b1; cyc(); err_clr = 1'b0;

      // Reset in the middle of a dump.
      for (int i = 0; i < 5; i++) send(2'b01, 16'hB000 + 16'(i), '0, n);
      send(2'b11, 16'h0, CW'(5), n);
      cyc(); cyc();
      held = out_data;
      chk("mid_dump_data", 32'(held), 32'hB002);
      #1 reset = 1'b1;
      #1;
      chk("abort_valid", {31'b0, out_valid}, 32'd0);
      chk("abort_depth", 32'(depth), 32'd0);
      cyc(); cyc();
      reset = 1'b0;
      chk("abort_ready", {31'b0, cmd_ready}, 32'd1);
      send(2'b10, 16'h0, '0, n);
      chk("abort_pop_unf", {31'b0, unf}, 32'd1);
      chk("abort_pop_valid", {31'b0, out_valid}, 32'd0);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         r = $urandom_range(0, 9);
         cmd_op    = (r < 4) ? 2'b01 : (r == 4) ? 2'b00 : (r < 7) ? 2'b10 : 2'b11;
         cmd_valid = ($urandom_range(0, 3) != 0);
         cmd_data  = 16'($urandom);
         cmd_count = CW'($urandom_range(0, 31));
         out_ready = ($urandom_range(0, 3) != 0);
         err_clr   = ($urandom_range(0, 15) == 0);
         cyc();
      end
      cmd_valid = 1'b0;
      err_clr = 1'b0;
      out_ready = 1'b1;
      repeat (25) cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
